tug_input_conditioner: RTL and testbench

//  Front end of the Tug of War datapath: turns the two raw player push-buttons into

---
 rtl/tug_pkg.sv | 10 +
 rtl/tug_button_conditioner.sv | 86 ++++++++
 rtl/tug_input_conditioner.sv | 42 ++++
 tb/tb_tug_input_conditioner.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tug_pkg.sv
// Shared types and default parameters for the Tug of War input front end.
package tug_pkg;

  typedef enum logic {RELEASED, PRESSED} btn_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned CNT_W_DEF           = 8;
  localparam int unsigned ACTIVE_LOW_DEF      = 1;

endpackage

// File: rtl/tug_button_conditioner.sv
// One player key: 2-flop sync, debounce, press FSM and a registered one-cycle press pulse.
module tug_button_conditioner
  import tug_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned ACTIVE_LOW      = ACTIVE_LOW_DEF
) (
  input  logic clk,
  input  logic Reset,
  input  logic key_raw,
  input  logic freeze,
  output logic press_pulse
);

  localparam logic             RawReleased = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CntLast     = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2, synced;
  logic             debounced;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       flush;
  logic             armed;
  btn_state_t       state;

  always_ff @(posedge clk) begin
    if (Reset) begin
      sync1 <= RawReleased;
      sync2 <= RawReleased;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  assign synced = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  always_ff @(posedge clk) begin
    if (Reset) begin
      debounced <= 1'b0;
      cnt       <= '0;
    end else if (synced != debounced) begin
      if (cnt == CntLast) begin
        debounced <= synced;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // A key held through Reset must be seen released (after the sync flops have
  // refilled with real samples) before it may produce a pulse again.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= RELEASED;
      press_pulse <= 1'b0;
      flush       <= 2'd0;
      armed       <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (flush != 2'd2) begin
        flush <= flush + 2'd1;
      end
      if (flush == 2'd2 && !synced && !debounced) begin
        armed <= 1'b1;
      end
      unique case (state)
        RELEASED: begin
          if (debounced) begin
            state       <= PRESSED;
            press_pulse <= armed & ~freeze;
          end
        end
        PRESSED: begin
          if (!debounced) begin
            state <= RELEASED;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/tug_input_conditioner.sv
// Tug of War front end: conditions the left and right player keys into L / R press pulses.
module tug_input_conditioner
  import tug_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned ACTIVE_LOW      = ACTIVE_LOW_DEF
) (
  input  logic clk,
  input  logic Reset,
  input  logic key_l,
  input  logic key_r,
  input  logic freeze,
  output logic L,
  output logic R
);

  tug_button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_left (
    .clk        (clk),
    .Reset      (Reset),
    .key_raw    (key_l),
    .freeze     (freeze),
    .press_pulse(L)
  );

  tug_button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_right (
    .clk        (clk),
    .Reset      (Reset),
    .key_raw    (key_r),
    .freeze     (freeze),
    .press_pulse(R)
  );

endmodule

// File: tb/tb_tug_input_conditioner.sv
// Randomised and directed bench for tug_input_conditioner against a cycle reference model.
module tb_tug_input_conditioner;

  localparam int DC = 4;

  logic clk = 1'b0;
  logic Reset, key_l, key_r, freeze;
  logic L, R;

  int checks   = 0;
  int failures = 0;

  tug_input_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (8),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .key_l (key_l),
    .key_r (key_r),
    .freeze(freeze),
    .L     (L),
    .R     (R)
  );

  always #5 clk = ~clk;

  // Reference model state, pressed=1 everywhere.
  bit p0[2], p1[2];  // raw samples one and two edges old
  bit deb[2];        // accepted level
  bit prev[2];       // accepted level as of the previous edge
  bit armed[2];      // seen released since reset
  int run[2];        // consecutive synced samples opposing the accepted level
  int since_rst;
  bit exp_p[2];

  // Apply one cycle of inputs (kl/kr = pressed), clock it, advance the model.
  task automatic cyc(input bit kl, input bit kr, input bit fz, input bit rst);
    bit pr[2];
    bit sy;
    key_l  = kl ? 1'b0 : 1'b1;
    key_r  = kr ? 1'b0 : 1'b1;
    freeze = fz;
    Reset  = rst;
    pr[0] = kl;
    pr[1] = kr;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        p0[k] = 0; p1[k] = 0; deb[k] = 0; prev[k] = 0; armed[k] = 0; run[k] = 0;
        exp_p[k] = 0;
      end else begin
        sy = p1[k];
        exp_p[k] = !prev[k] && deb[k] && armed[k] && !fz;
        if (since_rst >= 2 && !sy && !deb[k]) armed[k] = 1;
        prev[k] = deb[k];
        if (sy != deb[k]) begin
          run[k]++;
          if (run[k] == DC) begin
            deb[k] = sy;
            run[k] = 0;
          end
        end else begin
          run[k] = 0;
        end
        p1[k] = p0[k];
        p0[k] = pr[k];
      end
    end
    if (rst) since_rst = 0;
    else if (since_rst < 2) since_rst++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1);
      checks++;
      if (L !== 1'b0 || R !== 1'b0) begin
        failures++;
        $display("FAIL reset_state cyc%0d L=%b R=%b want 0 0", i, L, R);
      end
    end
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0);
      checks++;
      if (L !== 1'b0 || R !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d L=%b R=%b want 0 0", i, L, R);
      end
    end
  endtask

  task automatic test_press_hold();
    int nl = 0, nr = 0, first = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 0);
      checks++;
      if (L !== exp_p[0] || R !== exp_p[1]) begin
        failures++;
        $display("FAIL press_hold cyc%0d L=%b R=%b want %b %b", i, L, R, exp_p[0], exp_p[1]);
      end
      if (L === 1'b1) begin nl++; if (first < 0) first = i; end
      if (R === 1'b1) nr++;
    end
    checks++;
    if (nl != 1 || first != DC + 2 || nr != 0) begin
      failures++;
      $display("FAIL press_hold_count nl=%0d at=%0d nr=%0d want 1 at %0d and 0", nl, first, nr,
               DC + 2);
    end
    for (int i = 0; i < 15; i++) begin
      cyc(0, 0, 0, 0);
      checks++;
      if (L !== 1'b0 || R !== 1'b0) begin
        failures++;
        $display("FAIL press_release cyc%0d L=%b R=%b want 0 0", i, L, R);
      end
    end
  endtask

  task automatic test_bounce();
    bit pat[4];
    int nl = 0, first = -1;
    pat = '{1, 0, 1, 0};
    for (int i = 0; i < 20; i++) begin
      cyc((i < 4) ? pat[i] : 1'b1, 0, 0, 0);
      checks++;
      if (L !== exp_p[0]) begin
        failures++;
        $display("FAIL bounce_press cyc%0d L=%b want %b", i, L, exp_p[0]);
      end
      if (L === 1'b1) begin nl++; if (first < 0) first = i; end
    end
    checks++;
    if (nl != 1 || first != 4 + DC + 2) begin
      failures++;
      $display("FAIL bounce_count nl=%0d at=%0d want 1 at %0d", nl, first, 4 + DC + 2);
    end
    nl = 0;
    for (int i = 0; i < 20; i++) begin
      cyc((i < 4) ? ~pat[i] : 1'b0, 0, 0, 0);
      if (L === 1'b1) nl++;
    end
    checks++;
    if (nl != 0) begin
      failures++;
      $display("FAIL bounce_release pulses=%0d want 0", nl);
    end
  endtask

  task automatic test_simultaneous();
    int nl = 0, nr = 0, fl = -1, fr = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 0, 0);
      checks++;
      if (L !== exp_p[0] || R !== exp_p[1]) begin
        failures++;
        $display("FAIL simul cyc%0d L=%b R=%b want %b %b", i, L, R, exp_p[0], exp_p[1]);
      end
      if (L === 1'b1) begin nl++; if (fl < 0) fl = i; end
      if (R === 1'b1) begin nr++; if (fr < 0) fr = i; end
    end
    checks++;
    if (nl != 1 || nr != 1 || fl != fr || fl != DC + 2) begin
      failures++;
      $display("FAIL simul_count nl=%0d nr=%0d at %0d/%0d want 1 1 at %0d", nl, nr, fl, fr,
               DC + 2);
    end
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic test_freeze();
    int nr = 0, first = -1;
    for (int i = 0; i < 30; i++) begin
      cyc(0, 1, (i < 10), 0);
      checks++;
      if (R !== exp_p[1]) begin
        failures++;
        $display("FAIL freeze_hold cyc%0d R=%b want %b", i, R, exp_p[1]);
      end
      if (R === 1'b1) nr++;
    end
    checks++;
    if (nr != 0) begin
      failures++;
      $display("FAIL freeze_no_pulse pulses=%0d want 0", nr);
    end
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(0, 1, 0, 0);
      if (R === 1'b1) begin nr++; if (first < 0) first = i; end
    end
    checks++;
    if (nr != 1 || first != DC + 2) begin
      failures++;
      $display("FAIL freeze_repress pulses=%0d at=%0d want 1 at %0d", nr, first, DC + 2);
    end
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_hold();
    int nl = 0, first = -1;
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 25; i++) begin
      cyc(1, 0, 0, 0);
      checks++;
      if (L !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc%0d L=%b want 0", i, L);
      end
    end
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(1, 0, 0, 0);
      if (L === 1'b1) begin nl++; if (first < 0) first = i; end
    end
    checks++;
    if (nl != 1 || first != DC + 2) begin
      failures++;
      $display("FAIL reset_repress pulses=%0d at=%0d want 1 at %0d", nl, first, DC + 2);
    end
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit lv_l = 0, lv_r = 0, fz = 0, rst;
    int hold_l = 1, hold_r = 1, hold_f = 1;
    for (int i = 0; i < 1500; i++) begin
      if (--hold_l == 0) begin lv_l = ~lv_l; hold_l = $urandom_range(12, 1); end
      if (--hold_r == 0) begin lv_r = ~lv_r; hold_r = $urandom_range(12, 1); end
      if (--hold_f == 0) begin fz = ($urandom_range(3, 0) == 0); hold_f = $urandom_range(40, 5); end
      rst = ($urandom_range(199, 0) == 0);
      cyc(lv_l, lv_r, fz, rst);
      checks++;
      if (L !== exp_p[0] || R !== exp_p[1]) begin
        failures++;
        $display("FAIL random cyc%0d L=%b R=%b want %b %b", i, L, R, exp_p[0], exp_p[1]);
      end
    end
  endtask

  initial begin
    Reset  = 1'b1;
    key_l  = 1'b1;
    key_r  = 1'b1;
    freeze = 1'b0;
    since_rst = 0;
    test_reset();
    test_press_hold();
    test_bounce();
    test_simultaneous();
    test_freeze();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
